tutorial01_sw_poller: RTL and testbench

TUTORIAL01_SW_POLLER -- requirements
Module: tutorial01_sw_poller

---
 rtl/tutorial01_sw_poller.sv | 142 ++++++++++++++
 tb/tb_tutorial01_sw_poller.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tutorial01_sw_poller.sv
// rtl/tutorial01_sw_poller.sv - Avalon-MM switch poller with debounce and sticky change interrupt
module tutorial01_sw_poller #(
    parameter int unsigned POLL_DIV     = 1000,
    parameter int unsigned STABLE_COUNT = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    output logic [3:0]  m_address,
    output logic        m_read,
    input  logic        m_waitrequest,
    input  logic [31:0] m_readdata,
    output logic [2:0]  sw_state,
    output logic        sw_changed,
    output logic        irq,
    input  logic        irq_clear
);

    localparam logic [15:0] TIMER_LOAD = 16'(POLL_DIV - 1);
    localparam logic [3:0]  STABLE_MAX = 4'(STABLE_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT_DATA,
        ST_EVAL
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_timer;
    logic [15:0] w_timer_next;
    logic        r_data_phase;
    logic        w_data_phase_next;
    logic [2:0]  r_sample;
    logic [2:0]  w_sample_next;
    logic [2:0]  r_candidate;
    logic [2:0]  w_candidate_next;
    logic [3:0]  r_stable_cnt;
    logic [3:0]  w_stable_cnt_next;
    logic [3:0]  w_cnt_inc;
    logic        w_match;
    logic        w_accept;
    logic [2:0]  r_sw_state;
    logic        r_sw_changed;
    logic        r_irq;
    logic        w_unused_rdata;

    assign w_unused_rdata = ^m_readdata[31:3];
    assign w_match        = (r_sample == r_candidate);
    assign w_cnt_inc      = (r_stable_cnt >= STABLE_MAX) ? STABLE_MAX : r_stable_cnt + 4'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_timer      <= TIMER_LOAD;
            r_data_phase <= 1'b0;
            r_sample     <= 3'd0;
            r_candidate  <= 3'd0;
            r_stable_cnt <= 4'd0;
            r_sw_state   <= 3'd0;
            r_sw_changed <= 1'b0;
            r_irq        <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_timer      <= w_timer_next;
            r_data_phase <= w_data_phase_next;
            r_sample     <= w_sample_next;
            r_candidate  <= w_candidate_next;
            r_stable_cnt <= w_stable_cnt_next;
            r_sw_changed <= w_accept;
            if (w_accept) begin
                r_sw_state <= w_candidate_next;
            end
            // A new change event beats a simultaneous clear.
            if (w_accept) begin
                r_irq <= 1'b1;
            end else if (irq_clear) begin
                r_irq <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_timer_next      = r_timer;
        w_data_phase_next = r_data_phase;
        w_sample_next     = r_sample;
        w_candidate_next  = r_candidate;
        w_stable_cnt_next = r_stable_cnt;
        w_accept          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    if (r_timer == 16'd0) begin
                        w_state_next = ST_READ;
                        w_timer_next = TIMER_LOAD;
                    end else begin
                        w_timer_next = r_timer - 16'd1;
                    end
                end
            end
            ST_READ: begin
                if (!m_waitrequest) begin
                    w_state_next      = ST_WAIT_DATA;
                    w_data_phase_next = 1'b0;
                end
            end
            ST_WAIT_DATA: begin
                // First cycle covers the slave latency; readdata is taken on the second.
                if (r_data_phase) begin
                    w_sample_next     = m_readdata[2:0];
                    w_data_phase_next = 1'b0;
                    w_state_next      = ST_EVAL;
                end else begin
                    w_data_phase_next = 1'b1;
                end
            end
            ST_EVAL: begin
                if (w_match) begin
                    w_stable_cnt_next = w_cnt_inc;
                end else begin
                    w_candidate_next  = r_sample;
                    w_stable_cnt_next = 4'd1;
                end
                w_accept     = (w_stable_cnt_next == STABLE_MAX) &&
                               (w_candidate_next != r_sw_state);
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign m_address  = 4'h0;
    assign m_read     = (r_state == ST_READ);
    assign sw_state   = r_sw_state;
    assign sw_changed = r_sw_changed;
    assign irq        = r_irq;

endmodule

// File: tb/tb_tutorial01_sw_poller.sv
// tb/tb_tutorial01_sw_poller.sv - randomized self-checking bench for tutorial01_sw_poller
module tb_tutorial01_sw_poller;

    localparam int POLL_DIV = 8;
    localparam int STABLE   = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [3:0]  m_address;
    logic        m_read;
    logic        m_waitrequest = 1'b0;
    logic [31:0] m_readdata = 32'd0;
    logic [2:0]  sw_state;
    logic        sw_changed;
    logic        irq;
    logic        irq_clear = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int expected_start = 0;

    logic [2:0] history[$];
    logic [2:0] ref_sw = 3'd0;
    logic       ref_irq = 1'b0;
    logic       ref_changed = 1'b0;

    tutorial01_sw_poller #(.POLL_DIV(POLL_DIV), .STABLE_COUNT(STABLE)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .m_address(m_address), .m_read(m_read), .m_waitrequest(m_waitrequest),
        .m_readdata(m_readdata), .sw_state(sw_state), .sw_changed(sw_changed),
        .irq(irq), .irq_clear(irq_clear)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int trailing_run();
        int run = 0;
        for (int i = history.size() - 1; i >= 0; i--) begin
            if (history[i] == history[history.size() - 1]) run++;
            else break;
        end
        return run;
    endfunction

    task automatic model_reset();
        history.delete();
        ref_sw = 3'd0;
        ref_irq = 1'b0;
        ref_changed = 1'b0;
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({m_read, m_address, sw_state, sw_changed, irq} !== 10'd0) begin
            n_err++;
            $display("FAIL %s reset_values: got read=%b addr=%h sw=%b chg=%b irq=%b, want all 0",
                     tag, m_read, m_address, sw_state, sw_changed, irq);
        end
        model_reset();
        reset_n = 1'b1;
        expected_start = cyc + POLL_DIV;
    endtask

    task automatic serve_poll(input logic [2:0] val, input int stall, input logic clr_in_eval,
                              input logic drop_en);
        int n = 0;
        int rd_cycles = 0;
        int start;
        logic [31:0] junk;
        while (m_read !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (m_read !== 1'b1) begin
            n_err++;
            $display("FAIL poll_timeout: m_read=%b after %0d cycles, want 1", m_read, n);
            return;
        end
        start = cyc;
        n_vec++;
        if (start != expected_start) begin
            n_err++;
            $display("FAIL poll_start: m_read rose at cycle %0d, want %0d", start, expected_start);
        end
        junk = $urandom;
        m_readdata = {junk[31:3], ~val};
        for (int s = 0; s <= stall; s++) begin
            m_waitrequest = (s < stall);
            if (m_read === 1'b1 && m_address === 4'h0) rd_cycles++;
            @(negedge clk);
        end
        m_waitrequest = 1'b0;
        n_vec++;
        if (rd_cycles != stall + 1 || m_read !== 1'b0) begin
            n_err++;
            $display("FAIL read_hold: held %0d cycles then m_read=%b, want %0d then 0",
                     rd_cycles, m_read, stall + 1);
        end
        junk = $urandom;
        m_readdata = {junk[31:3], val};
        if (drop_en) enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        junk = $urandom;
        m_readdata = {junk[31:3], ~val};
        irq_clear = clr_in_eval;
        @(negedge clk);
        irq_clear = 1'b0;
        history.push_back(val);
        ref_changed = (trailing_run() == STABLE) && (val != ref_sw);
        if (ref_changed) begin
            ref_sw = val;
            ref_irq = 1'b1;
        end else if (clr_in_eval) begin
            ref_irq = 1'b0;
        end
        expected_start = start + stall + 4 + POLL_DIV;
        n_vec++;
        if (sw_state !== ref_sw || sw_changed !== ref_changed || irq !== ref_irq) begin
            n_err++;
            $display("FAIL eval_result: sw=%b chg=%b irq=%b, want sw=%b chg=%b irq=%b",
                     sw_state, sw_changed, irq, ref_sw, ref_changed, ref_irq);
        end
        @(negedge clk);
        n_vec++;
        if (sw_changed !== 1'b0 || sw_state !== ref_sw) begin
            n_err++;
            $display("FAIL pulse_width: chg=%b sw=%b, want chg=0 sw=%b", sw_changed, sw_state, ref_sw);
        end
    endtask

    task automatic test_reset();
        enable = 1'b1;
        apply_reset("initial");
    endtask

    task automatic test_debounce_basic();
        for (int i = 0; i < 4; i++) serve_poll(3'h5, 0, 1'b0, 1'b0);
        n_vec++;
        if (sw_state !== 3'b101 || irq !== 1'b1) begin
            n_err++;
            $display("FAIL basic_final: sw=%b irq=%b, want sw=101 irq=1", sw_state, irq);
        end
    endtask

    task automatic test_sequence();
        logic [2:0] seq[6] = '{3'h1, 3'h1, 3'h2, 3'h1, 3'h1, 3'h1};
        apply_reset("sequence");
        foreach (seq[i]) serve_poll(seq[i], 0, 1'b0, 1'b0);
        n_vec++;
        if (sw_state !== 3'b001) begin
            n_err++;
            $display("FAIL sequence_final: sw=%b, want 001", sw_state);
        end
    endtask

    task automatic test_stall();
        serve_poll(3'h1, 20, 1'b0, 1'b0);
        serve_poll(3'h1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_irq_clear();
        @(negedge clk);
        irq_clear = 1'b1;
        @(negedge clk);
        irq_clear = 1'b0;
        ref_irq = 1'b0;
        expected_start = expected_start;
        n_vec++;
        if (irq !== 1'b0) begin
            n_err++;
            $display("FAIL irq_preclear: irq=%b, want 0", irq);
        end
        serve_poll(3'h3, 0, 1'b0, 1'b0);
        serve_poll(3'h3, 0, 1'b0, 1'b0);
        serve_poll(3'h3, 0, 1'b1, 1'b0);
        irq_clear = 1'b1;
        @(negedge clk);
        irq_clear = 1'b0;
        ref_irq = 1'b0;
        n_vec++;
        if (irq !== 1'b0) begin
            n_err++;
            $display("FAIL irq_clear_after: irq=%b, want 0", irq);
        end
    endtask

    task automatic test_enable();
        int reads = 0;
        int hold = 15;
        serve_poll(3'h3, 0, 1'b0, 1'b1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (m_read !== 1'b0) reads++;
        end
        n_vec++;
        if (reads != 0) begin
            n_err++;
            $display("FAIL enable_hold: %0d read cycles while disabled, want 0", reads);
        end
        enable = 1'b1;
        expected_start = expected_start + hold + 1;
        serve_poll(3'h3, 0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_read();
        int n = 0;
        for (int i = 0; i < 3; i++) serve_poll(3'h6, 0, 1'b0, 1'b0);
        while (m_read !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        #2 reset_n = 1'b0;
        #1;
        n_vec++;
        if (m_read !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async_read: m_read=%b, want 0", m_read);
        end
        @(negedge clk);
        m_readdata = 32'hFFFF_FFFA;
        n_vec++;
        if ({m_read, m_address, sw_state, sw_changed, irq} !== 10'd0) begin
            n_err++;
            $display("FAIL reset_mid_values: read=%b addr=%h sw=%b chg=%b irq=%b, want all 0",
                     m_read, m_address, sw_state, sw_changed, irq);
        end
        @(negedge clk);
        model_reset();
        reset_n = 1'b1;
        expected_start = cyc + POLL_DIV;
        serve_poll(3'h4, 0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [2:0] val = 3'h2;
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) == 0) val = 3'($urandom_range(0, 7));
            serve_poll(val, $urandom_range(0, 3), 1'($urandom_range(0, 2) == 0), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_debounce_basic();
        test_sequence();
        test_stall();
        test_irq_clear();
        test_enable();
        test_reset_mid_read();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
